// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared types and RV32I opcode constants for the multicycle controller
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_TRAP    = 3'd6
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2,
    PC_JALR   = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic is_valid_opcode(input logic [6:0] op);
    return (op == OP_ALU)    || (op == OP_ALUI)  || (op == OP_LOAD)  ||
           (op == OP_STORE)  || (op == OP_BRANCH) || (op == OP_JAL)  ||
           (op == OP_JALR)   || (op == OP_LUI)    || (op == OP_AUIPC);
  endfunction

endpackage

// File: rtl/retire_counter.sv
// rtl/retire_counter.sv - 64-bit enable-driven counter, wraps to zero
module retire_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  assign count_d = en_i ? count_q + 64'd1 : count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 64'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multi-cycle control FSM (fetch/decode/execute/mem/wb)
// Optional retired-instruction counter under MULTICYCLE_RETIRE_CNT_EN.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] inst_i,
  output logic        imem_req_o,
  input  logic        imem_rvalid_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_rvalid_i,
  input  logic        branch_taken_i,
  output logic [6:0]  opcode_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic [31:0] pc_reset_val_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        illegal_o,
  output logic [2:0]  state_o
`ifdef MULTICYCLE_RETIRE_CNT_EN
  ,
  output logic [63:0] instret_o
`endif
);

  ctrl_state_e state_q, state_d;
  logic [6:0]  opcode_q;

  logic is_load, is_store, is_branch;
  assign is_load   = (opcode_q == OP_LOAD);
  assign is_store  = (opcode_q == OP_STORE);
  assign is_branch = (opcode_q == OP_BRANCH);

  // Only the opcode field is consumed here; the rest of the word goes to the datapath.
  logic unused_inst;
  assign unused_inst = ^inst_i[31:7];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opcode_q <= 7'h00;
    end else if (state_q == ST_FETCH && imem_rvalid_i) begin
      opcode_q <= inst_i[6:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START:   state_d = ST_FETCH;
      ST_FETCH:   if (imem_rvalid_i) state_d = ST_DECODE;
      ST_DECODE:  state_d = is_valid_opcode(opcode_q) ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE: begin
        if (is_branch)                 state_d = ST_FETCH;
        else if (is_load || is_store)  state_d = ST_MEM;
        else                           state_d = ST_WB;
      end
      ST_MEM:     if (dmem_rvalid_i) state_d = is_store ? ST_FETCH : ST_WB;
      ST_WB:      state_d = ST_FETCH;
      ST_TRAP:    state_d = ST_TRAP;
      default:    state_d = ST_START;
    endcase
  end

  always_comb begin
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    pc_we_o    = 1'b0;
    pc_sel_o   = PC_PLUS4;
    rf_we_o    = 1'b0;
    wb_sel_o   = WB_ALU;
    illegal_o  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        ir_we_o    = imem_rvalid_i;
      end
      ST_EXECUTE: begin
        if (is_branch) begin
          pc_we_o  = 1'b1;
          pc_sel_o = branch_taken_i ? PC_BRANCH : PC_PLUS4;
        end
      end
      ST_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store;
        pc_we_o    = is_store && dmem_rvalid_i;
      end
      ST_WB: begin
        rf_we_o = 1'b1;
        pc_we_o = 1'b1;
        if (is_load)                                          wb_sel_o = WB_MEM;
        else if (opcode_q == OP_JAL || opcode_q == OP_JALR)   wb_sel_o = WB_PC4;
        else if (opcode_q == OP_LUI)                          wb_sel_o = WB_IMM;
        if (opcode_q == OP_JAL)       pc_sel_o = PC_JAL;
        else if (opcode_q == OP_JALR) pc_sel_o = PC_JALR;
      end
      ST_TRAP:  illegal_o = 1'b1;
      default: ;
    endcase
  end

  assign opcode_o       = opcode_q;
  assign state_o        = state_q;
  assign pc_reset_val_o = RESET_PC;

`ifdef MULTICYCLE_RETIRE_CNT_EN
  retire_counter u_retire_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (pc_we_o),
    .count_o (instret_o)
  );
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] inst_i = 32'h0;
  logic        imem_rvalid_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic        imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, rf_we_o, illegal_o;
  logic [6:0]  opcode_o;
  logic [1:0]  pc_sel_o, wb_sel_o;
  logic [31:0] pc_reset_val_o;
  logic [2:0]  state_o;
`ifdef MULTICYCLE_RETIRE_CNT_EN
  logic [63:0] instret_o;
`endif

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .inst_i         (inst_i),
    .imem_req_o     (imem_req_o),
    .imem_rvalid_i  (imem_rvalid_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .branch_taken_i (branch_taken_i),
    .opcode_o       (opcode_o),
    .ir_we_o        (ir_we_o),
    .pc_we_o        (pc_we_o),
    .pc_sel_o       (pc_sel_o),
    .pc_reset_val_o (pc_reset_val_o),
    .rf_we_o        (rf_we_o),
    .wb_sel_o       (wb_sel_o),
    .illegal_o      (illegal_o),
    .state_o        (state_o)
`ifdef MULTICYCLE_RETIRE_CNT_EN
    ,
    .instret_o      (instret_o)
`endif
  );

  typedef struct {
    logic        rst_low;
    logic [31:0] inst;
    logic        iv, dv, tk;
    logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, illegal;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;
    logic [6:0]  opcode;
    logic [63:0] instret;
  } cyc_t;

  localparam logic [2:0] S_START = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

  cyc_t        q[$];
  logic [6:0]  m_op;
  logic [63:0] m_ir;
  int          errors = 0;
  int          checks = 0;
  int          pc_we_seen = 0;

  function automatic logic legal(input logic [6:0] op);
    case (op)
      7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic cyc_t base(input logic [2:0] st, input logic [31:0] inst,
                                input logic iv, input logic dv, input logic tk);
    cyc_t c;
    c.rst_low = 1'b0; c.inst = inst; c.iv = iv; c.dv = dv; c.tk = tk;
    c.imem_req = 0; c.ir_we = 0; c.dmem_req = 0; c.dmem_we = 0; c.pc_we = 0;
    c.rf_we = 0; c.illegal = 0; c.pc_sel = 2'd0; c.wb_sel = 2'd0;
    c.state = st; c.opcode = m_op; c.instret = m_ir;
    return c;
  endfunction

  task automatic push(input cyc_t c);
    q.push_back(c);
    if (c.pc_we) m_ir = m_ir + 64'd1;
  endtask

  task automatic plan_reset(input int n);
    cyc_t c;
    m_op = 7'h00;
    m_ir = 64'd0;
    for (int i = 0; i < n; i++) begin
      c = base(S_START, 32'h0, 1'b1, 1'b1, 1'b0);
      c.rst_low = 1'b1;
      push(c);
    end
    // First cycle after release: still START, stray responses must be ignored.
    c = base(S_START, 32'h0, 1'b1, 1'b1, 1'b0);
    push(c);
  endtask

  task automatic plan_instr(input logic [31:0] inst, input int iwait, input int dwait,
                            input logic tk, input logic stray, input logic abort_mem,
                            input int trap_cycles);
    cyc_t c;
    logic [6:0] op;
    logic ld, st;
    op = inst[6:0];
    ld = (op == 7'h03);
    st = (op == 7'h23);
    for (int i = 0; i < iwait; i++) begin
      c = base(S_FETCH, inst, 1'b0, stray, tk); c.imem_req = 1; push(c);
    end
    c = base(S_FETCH, inst, 1'b1, stray, tk); c.imem_req = 1; c.ir_we = 1; push(c);
    m_op = op;
    c = base(S_DECODE, inst, stray, stray, tk); push(c);
    if (!legal(op)) begin
      for (int i = 0; i < trap_cycles; i++) begin
        c = base(S_TRAP, inst, stray, stray, tk); c.illegal = 1; push(c);
      end
      return;
    end
    c = base(S_EXEC, inst, stray, stray, tk);
    if (op == 7'h63) begin
      c.pc_we = 1; c.pc_sel = tk ? 2'd1 : 2'd0;
      push(c);
      return;
    end
    push(c);
    if (ld || st) begin
      for (int i = 0; i < dwait; i++) begin
        c = base(S_MEM, inst, stray, 1'b0, tk); c.dmem_req = 1; c.dmem_we = st; push(c);
      end
      if (abort_mem) return;
      c = base(S_MEM, inst, stray, 1'b1, tk); c.dmem_req = 1; c.dmem_we = st;
      if (st) begin
        c.pc_we = 1;
        push(c);
        return;
      end
      push(c);
    end
    c = base(S_WB, inst, stray, stray, tk);
    c.rf_we = 1; c.pc_we = 1;
    c.wb_sel = ld ? 2'd1 : (op == 7'h6F || op == 7'h67) ? 2'd2 : (op == 7'h37) ? 2'd3 : 2'd0;
    c.pc_sel = (op == 7'h6F) ? 2'd2 : (op == 7'h67) ? 2'd3 : 2'd0;
    push(c);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] pack_exp(input cyc_t c);
    return {c.imem_req, c.ir_we, c.dmem_req, c.dmem_we, c.pc_we, c.pc_sel,
            c.rf_we, c.wb_sel, c.illegal, c.state, c.opcode};
  endfunction

  initial begin
    int n0;
    cyc_t c;
    m_op = 7'h00;
    m_ir = 64'd0;

    plan_reset(2);
    for (int k = 0; k < 3; k++) begin
      n0 = q.size(); plan_instr(32'h00500093, 0, 0, 1'b0, 1'b1, 1'b0, 0);
      chk("len_addi", 64'(q.size() - n0), 64'd4);
    end
    n0 = q.size(); plan_instr(32'h0000A103, 1, 3, 1'b0, 1'b0, 1'b0, 0);
    chk("len_lw_waits", 64'(q.size() - n0), 64'd9);
    n0 = q.size(); plan_instr(32'h0000A023, 0, 2, 1'b0, 1'b1, 1'b0, 0);
    chk("len_sw_waits", 64'(q.size() - n0), 64'd6);
    n0 = q.size(); plan_instr(32'h0000A103, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    chk("len_lw", 64'(q.size() - n0), 64'd5);
    n0 = q.size(); plan_instr(32'h0000A023, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("len_sw", 64'(q.size() - n0), 64'd4);
    n0 = q.size(); plan_instr(32'h00000463, 0, 0, 1'b1, 1'b1, 1'b0, 0);
    chk("len_beq_t", 64'(q.size() - n0), 64'd3);
    n0 = q.size(); plan_instr(32'h00000463, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    chk("len_beq_nt", 64'(q.size() - n0), 64'd3);
    plan_instr(32'h0080006F, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    plan_instr(32'h00008067, 2, 0, 1'b0, 1'b0, 1'b0, 0);
    plan_instr(32'h123450B7, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    plan_instr(32'h00001097, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    plan_instr(32'h002081B3, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    plan_instr(32'h0000A103, 0, 2, 1'b0, 1'b0, 1'b1, 0);
    plan_reset(1);
    plan_instr(32'h00500093, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    plan_instr(32'h0000007F, 0, 0, 1'b0, 1'b1, 1'b0, 20);
    plan_reset(1);
    plan_instr(32'h00500093, 0, 0, 1'b0, 1'b1, 1'b0, 0);

    for (int i = 0; i < q.size(); i++) begin
      c = q[i];
      @(posedge clk);
      #1;
      rst_ni         = !c.rst_low;
      inst_i         = c.inst;
      imem_rvalid_i  = c.iv;
      dmem_rvalid_i  = c.dv;
      branch_taken_i = c.tk;
      @(negedge clk);
      chk($sformatf("cyc%0d_st%0d", i, c.state),
          64'({imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, pc_we_o, pc_sel_o,
               rf_we_o, wb_sel_o, illegal_o, state_o, opcode_o}),
          64'(pack_exp(c)));
`ifdef MULTICYCLE_RETIRE_CNT_EN
      chk($sformatf("cyc%0d_instret", i), instret_o, c.instret);
`endif
      if (pc_we_o === 1'b1) pc_we_seen++;
    end
    chk("pc_reset_val", 64'(pc_reset_val_o), 64'h0);
    chk("pc_we_total", 64'(pc_we_seen), 64'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the RV32I core. It sequences instruction fetch, decode, execute, memory and writeback over the shared datapath.
- Captures the instruction opcode and drives it to sign_extension and the ALU decode. Also drives the PC, register-file and memory control strobes.
- Sits between the instruction/data memory interfaces and the datapath. Only one instruction is in flight at a time.

Parameters:
- RESET_PC, 32'h0000_0000, PC value requested on the first fetch (passed through on pc_reset_val_o).

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  asynchronous, active-low reset
- inst_i  input  32  instruction read data from imem
- imem_req_o  output  1  fetch request, held until imem_rvalid_i
- imem_rvalid_i  input  1  fetch data valid; may assert in the same cycle as the request
- dmem_req_o  output  1  data access request, held until dmem_rvalid_i
- dmem_we_o  output  1  1 = store, 0 = load; valid while dmem_req_o = 1
- dmem_rvalid_i  input  1  data access complete
- branch_taken_i  input  1  branch comparator result, valid in EXECUTE
- opcode_o  output  7  registered opcode (inst_i[6:0]) fed to sign_extension
- ir_we_o  output  1  instruction register load strobe
- pc_we_o  output  1  PC write strobe
- pc_sel_o  output  2  PC source: 0 = PLUS4, 1 = BRANCH, 2 = JAL, 3 = JALR
- pc_reset_val_o  output  32  RESET_PC constant
- rf_we_o  output  1  register-file write strobe
- wb_sel_o  output  2  writeback source: 0 = ALU, 1 = MEM, 2 = PC+4, 3 = IMM
- illegal_o  output  1  sticky illegal-opcode flag
- state_o  output  3  current state, for debug

Behaviour:
- States: START, FETCH, DECODE, EXECUTE, MEM, WB, TRAP. Reset state is START.
- Async reset returns to START from any state, including mid-fetch or mid-access.
  - All outputs are 0 in reset and in START; opcode_o resets to 7'h00.
- START -> FETCH after one cycle.
- FETCH:
  - imem_req_o = 1 every cycle in this state.
  - On imem_rvalid_i = 1: ir_we_o = 1 for that cycle, opcode_o <= inst_i[6:0], then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle):
  - Valid opcodes are those in pkg_config: OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - Any other opcode -> TRAP; otherwise -> EXECUTE.
- EXECUTE (1 cycle):
  - OP_BRANCH: pc_we_o = 1, pc_sel_o = branch_taken_i ? BRANCH : PLUS4, then go to FETCH.
  - OP_LOAD / OP_STORE: go to MEM.
  - All other valid opcodes: go to WB.
- MEM:
  - dmem_req_o = 1, with dmem_we_o = (opcode_o == OP_STORE); both held until dmem_rvalid_i.
  - On dmem_rvalid_i: a store asserts pc_we_o = 1 with PLUS4 and goes to FETCH; a load goes to WB.
- WB (1 cycle):
  - rf_we_o = 1 and pc_we_o = 1.
  - wb_sel_o: LOAD = MEM, JAL/JALR = PC+4, LUI = IMM, others = ALU.
  - pc_sel_o: JAL = JAL, JALR = JALR, else PLUS4.
  - Then go to FETCH.
- TRAP: illegal_o = 1. All strobes and requests are 0. The FSM leaves TRAP only on reset.
- Strobe outputs are Moore outputs, except the rvalid-qualified ones (ir_we_o, MEM pc_we_o).
- imem_rvalid_i outside FETCH and dmem_rvalid_i outside MEM are ignored. This includes a late response after reset.
- Cycle counts with zero-wait memory:
  - ALU / ALUI / LUI / AUIPC / JAL / JALR: 4 cycles (FETCH, DECODE, EXECUTE, WB)
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - BRANCH: 3 cycles
- At most one of pc_we_o and ir_we_o is high in any cycle.

Optional Feature:
- Macro: MULTICYCLE_RETIRE_CNT_EN.
- Defined: adds output instret_o (64 bits). It resets to 0 and increments by 1 in every cycle where pc_we_o = 1. It wraps from 2^64-1 to 0 and never counts in TRAP.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- pkg_config additions:
  - ctrl_state_e (3-bit enum of the seven states)
  - pc_sel_e and wb_sel_e (2-bit enums)
  - OP_ALU constant, if it is not already present (existing OP_* constants are reused)
- Sub-module: retire_counter (64-bit enable-driven counter), instantiated only under MULTICYCLE_RETIRE_CNT_EN. No other sub-module; the FSM stays in one file.

Test Plan:
- Reset, release, imem_rvalid_i tied 1 with inst 0x00500093 (addi) -> START, then FETCH/DECODE/EXECUTE/WB. rf_we_o = 1 and wb_sel_o = 0 in WB; pc_we_o is high once per instruction, with a 4-cycle period.
- lw 0x0000A103 with dmem_rvalid_i delayed 3 cycles -> dmem_req_o = 1 and dmem_we_o = 0 held 4 cycles; then WB with wb_sel_o = 1 and rf_we_o = 1.
- sw 0x0000A023 -> in MEM, dmem_we_o = 1; pc_we_o = 1 in the dmem_rvalid_i cycle; rf_we_o is never asserted.
- beq 0x00000463, first with branch_taken_i = 1 then with 0 -> pc_sel_o = 1 then 0 in EXECUTE; 3 cycles per instruction; no WB.
- Illegal inst 0x0000007F -> TRAP after DECODE; illegal_o = 1 and all requests stay 0 for 20 cycles. Reset clears illegal_o.
- Assert rst_ni low while dmem_req_o = 1, then pulse dmem_rvalid_i after release -> req drops immediately, the FSM restarts at START, and the stray rvalid is ignored. With MULTICYCLE_RETIRE_CNT_EN, instret_o = 0.
